// File: rtl/mastermind_uart_pkg.sv
// Shared definitions for the Mastermind status-report UART transmitter.
// Holds the default bit period, the ASCII constants used in a report,
// the state encodings of both FSMs and the report byte formatter.
package mastermind_uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ASCII_R     = 8'h52;  // 'R'
  localparam logic [7:0] ASCII_Z     = 8'h5A;  // 'Z'
  localparam logic [7:0] ASCII_LOW_Z = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;  // '0'
  localparam logic [7:0] ASCII_QMARK = 8'h3F;  // '?'

  typedef enum logic {
    TOP_IDLE,
    TOP_SENDING
  } top_state_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_START,
    SER_DATA,
    SER_STOP
  } ser_state_t;

  // Single decimal digit; values above 9 cannot be shown and become '?'.
  function automatic logic [7:0] digit(input logic [3:0] v);
    if (v <= 4'd9) begin
      return ASCII_0 + {4'h0, v};
    end
    return ASCII_QMARK;
  endfunction

  // Byte idx of the report "R<r>Z<zn>z<zo>\r\n".
  function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                             input logic [3:0] rnd,
                                             input logic [3:0] zn,
                                             input logic [3:0] zo);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ASCII_R;
      3'd1:    b = digit(rnd);
      3'd2:    b = ASCII_Z;
      3'd3:    b = digit(zn);
      3'd4:    b = ASCII_LOW_Z;
      3'd5:    b = digit(zo);
      3'd6:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mastermind_uart_tx_byte.sv
// Single-byte 8N1 serializer.
// Ports:
//   clock, reset (async, active-high)
//   start      - load data and begin a frame; honoured in IDLE and in the
//                last cycle of the stop bit (back-to-back frames)
//   data[7:0]  - byte to send, sampled when start is accepted
//   tx         - registered serial output, idle high
//   byte_done  - high during the last cycle of the stop bit
module uart_tx_byte
  import mastermind_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  ser_state_t  r_state, w_state_next;
  logic [15:0] r_baud,  w_baud_next;
  logic [2:0]  r_bit,   w_bit_next;
  logic [7:0]  r_data,  w_data_next;
  logic        r_tx,    w_tx_next;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SER_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud <= '0;
      r_bit  <= '0;
      r_data <= '0;
      r_tx   <= 1'b1;
    end else begin
      r_baud <= w_baud_next;
      r_bit  <= w_bit_next;
      r_data <= w_data_next;
      r_tx   <= w_tx_next;
    end
  end

  // tx is computed one cycle ahead so the line is always a flop output.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_data_next  = r_data;
    w_tx_next    = r_tx;

    if (r_state != SER_IDLE) begin
      w_baud_next = w_bit_end ? '0 : r_baud + 16'd1;
    end

    case (r_state)
      SER_IDLE: begin
        if (start) begin
          w_state_next = SER_START;
          w_data_next  = data;
          w_bit_next   = '0;
          w_tx_next    = 1'b0;
        end
      end
      SER_START: begin
        if (w_bit_end) begin
          w_state_next = SER_DATA;
          w_bit_next   = '0;
          w_tx_next    = r_data[0];
        end
      end
      SER_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_next = SER_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_next = r_bit + 3'd1;
            w_tx_next  = r_data[r_bit + 3'd1];
          end
        end
      end
      SER_STOP: begin
        if (w_bit_end) begin
          if (start) begin
            w_state_next = SER_START;
            w_data_next  = data;
            w_bit_next   = '0;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = SER_IDLE;
            w_tx_next    = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = SER_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign tx        = r_tx;
  assign byte_done = (r_state == SER_STOP) && w_bit_end;

endmodule

// File: rtl/mastermind_uart_tx.sv
// Mastermind status reporter: on send, transmits "R<round>Z<znarly>z<zood>\r\n"
// over an 8N1 UART line.
// Ports:
//   clock, reset (async, active-high)
//   send          - one-cycle request; accepted only when idle and not in
//                   the done cycle
//   round_number, znarly, zood [3:0] - values snapshotted on accept
//   tx            - serial line, idle high
//   busy          - high for the whole report (80 bit periods)
//   done          - one-cycle pulse in the cycle busy falls
module mastermind_uart_tx
  import mastermind_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [3:0] round_number,
  input  logic [3:0] znarly,
  input  logic [3:0] zood,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  top_state_t r_state, w_state_next;
  logic [2:0] r_idx,    w_idx_next;
  logic [3:0] r_round,  w_round_next;
  logic [3:0] r_znarly, w_znarly_next;
  logic [3:0] r_zood,   w_zood_next;
  logic       r_busy,   w_busy_next;
  logic       r_done,   w_done_next;

  logic       w_byte_start;
  logic [7:0] w_byte_data;
  logic       w_byte_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= TOP_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_round  <= '0;
      r_znarly <= '0;
      r_zood   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_idx    <= w_idx_next;
      r_round  <= w_round_next;
      r_znarly <= w_znarly_next;
      r_zood   <= w_zood_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  // Byte 0 is launched in the accept cycle, before the snapshot registers
  // are loaded, so it is formatted from the live inputs; every later byte
  // is handed over in the final stop-bit cycle of its predecessor.
  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_round_next  = r_round;
    w_znarly_next = r_znarly;
    w_zood_next   = r_zood;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_byte_start  = 1'b0;
    w_byte_data   = report_byte(r_idx + 3'd1, r_round, r_znarly, r_zood);

    case (r_state)
      TOP_IDLE: begin
        if (send && !r_done) begin
          w_state_next  = TOP_SENDING;
          w_idx_next    = '0;
          w_round_next  = round_number;
          w_znarly_next = znarly;
          w_zood_next   = zood;
          w_busy_next   = 1'b1;
          w_byte_start  = 1'b1;
          w_byte_data   = report_byte(3'd0, round_number, znarly, zood);
        end
      end
      TOP_SENDING: begin
        if (w_byte_done) begin
          if (r_idx == 3'd7) begin
            w_state_next = TOP_IDLE;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_byte_start = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = TOP_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock     (clock),
    .reset     (reset),
    .start     (w_byte_start),
    .data      (w_byte_data),
    .tx        (tx),
    .byte_done (w_byte_done)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mastermind_uart_tx.sv
module tb_mastermind_uart_tx;

  localparam int unsigned CPB           = 4;
  localparam int unsigned REPORT_CYCLES = 80 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       send;
  logic [3:0] round_number;
  logic [3:0] znarly;
  logic [3:0] zood;
  logic       tx;
  logic       busy;
  logic       done;

  mastermind_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .send         (send),
    .round_number (round_number),
    .znarly       (znarly),
    .zood         (zood),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int unsigned cyc = 0;
  int unsigned next_free = 0;
  int          reports_expected = 0;
  int          done_seen = 0;
  int unsigned bm_len = 0;
  logic        bm_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] ascii_digit(input int v);
    if (v < 10) return 8'(48 + v);
    return 8'd63;
  endfunction

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // Reference model: a request is taken only if no report is in flight and
  // the previous report's done cycle has passed.
  task automatic do_send(input logic [3:0] r, input logic [3:0] zn, input logic [3:0] zo);
    bit acc;
    round_number = r;
    znarly       = zn;
    zood         = zo;
    send         = 1'b1;
    acc = (cyc >= next_free);
    if (acc) begin
      next_free = cyc + 2 + REPORT_CYCLES;
      reports_expected++;
      exp_q.push_back(8'h52);
      exp_q.push_back(ascii_digit(int'(r)));
      exp_q.push_back(8'h5A);
      exp_q.push_back(ascii_digit(int'(zn)));
      exp_q.push_back(8'h7A);
      exp_q.push_back(ascii_digit(int'(zo)));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    tick();
    send = 1'b0;
    if (acc) begin
      check("accept_busy", busy, 1);
      check("accept_start_bit", tx, 0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    if (cyc < next_free) reports_expected--;
    exp_q.delete();
    next_free = 0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned w = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && w < 2 * REPORT_CYCLES) begin
      tick();
      w++;
    end
    check(name, {30'd0, busy, done}, 0);
  endtask

  // UART receiver: every cycle of every bit must hold the same level.
  task automatic receive_frame();
    logic [9:0] bits;
    bit steady  = 1'b1;
    bit aborted = 1'b0;
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      for (int s = 0; s < int'(CPB); s++) begin
        if (!(b == 0 && s == 0)) @(negedge clock);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        if (s == 0) bits[b] = tx;
        else if (tx !== bits[b]) steady = 1'b0;
      end
      if (aborted) break;
    end
    if (aborted) return;
    check("bit_width_steady", {31'd0, steady}, 1);
    check("start_bit", bits[0], 0);
    check("stop_bit", bits[9], 1);
    if (exp_q.size() == 0) begin
      check("byte_expected", {24'd0, bits[8:1]}, 32'h100);
    end else begin
      check("rx_byte", bits[8:1], exp_q.pop_front());
    end
  endtask

  initial begin : uart_rx
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) receive_frame();
    end
  end

  initial begin : busy_mon
    forever begin
      @(negedge clock);
      if (reset) begin
        bm_len  = 0;
        bm_prev = 1'b0;
      end else begin
        if (busy) begin
          bm_len++;
        end else if (bm_prev) begin
          check("busy_len", bm_len, REPORT_CYCLES);
          check("done_at_busy_fall", done, 1);
          check("tx_high_at_done", tx, 1);
          bm_len = 0;
        end
        if (done) begin
          done_seen++;
          check("done_only_at_busy_fall", {31'd0, bm_prev && !busy}, 1);
        end
        bm_prev = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned wd;
    reset        = 1'b1;
    send         = 1'b0;
    round_number = '0;
    znarly       = '0;
    zood         = '0;
    tick();
    tick();
    check("por_tx", tx, 1);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    reset = 1'b0;
    tick();

    // basic report
    do_send(4'd3, 4'd2, 4'd1);
    wait_idle("idle_after_basic");

    // out-of-range digits
    do_send(4'd12, 4'd0, 4'd15);
    wait_idle("idle_after_qmark");

    // snapshot and ignored send while busy
    do_send(4'd7, 4'd1, 4'd9);
    repeat (9) tick();
    round_number = 4'd2;
    znarly       = 4'd8;
    zood         = 4'd4;
    repeat (39) tick();
    do_send(4'd0, 4'd0, 4'd0);
    wait_idle("idle_after_snapshot");

    // reset mid-report, then a full report
    do_send(4'd9, 4'd4, 4'd2);
    repeat (99) tick();
    apply_reset();
    tick();
    do_send(4'd9, 4'd4, 4'd2);
    wait_idle("idle_after_reset_report");

    // send in the done cycle is dropped, the next cycle is taken
    do_send(4'd1, 4'd5, 4'd6);
    wd = 0;
    while (done !== 1'b1 && wd < 2 * REPORT_CYCLES) begin
      tick();
      wd++;
    end
    check("done_reached", done, 1);
    do_send(4'd5, 4'd5, 4'd5);
    check("done_cycle_send_busy", busy, 0);
    check("done_cycle_send_tx", tx, 1);
    do_send(4'd6, 4'd7, 4'd8);
    wait_idle("idle_after_back_to_back");

    // randomized reports with stray requests during transmission
    for (int k = 0; k < 4; k++) begin
      do_send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 300)) tick();
      do_send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_idle("idle_after_random");
      repeat ($urandom_range(0, 4)) tick();
    end

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, reports_expected);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mastermind_uart_tx.md
MASTERMIND_UART_TX -- requirements
Module: mastermind_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Port: clock  input  1  system clock (CLOCK_50 domain).
REQ-003 Port: reset  input  1  asynchronous, active-high.
REQ-004 Port: send  input  1  single-cycle request to transmit one status report.
REQ-005 Port: round_number  input  4  current round, binary.
REQ-006 Port: znarly  input  4  Znarly count, binary.
REQ-007 Port: zood  input  4  Zood count, binary.
REQ-008 Port: tx  output  1  UART serial line (drives UART_TXD); idle high.
REQ-009 Port: busy  output  1  high while a report is being transmitted.
REQ-010 Port: done  output  1  one-cycle pulse when a report completes.

Function
REQ-011 Line format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-012 Report SHALL be 8 bytes in order: 'R'(0x52), digit(round_number), 'Z'(0x5A), digit(znarly), 'z'(0x7A), digit(zood), CR(0x0D), LF(0x0A).
REQ-013 digit(v) SHALL be 0x30+v for v in 0..9; 0x3F ('?') for v in 10..15.
REQ-014 send with busy=0 SHALL be accepted: round_number/znarly/zood snapshotted that cycle; later input changes do not affect the report.
REQ-015 send with busy=1 SHALL be ignored (not queued).
REQ-016 On accept, busy SHALL rise and tx SHALL go low (start bit) on the next clock edge.
REQ-017 Bytes SHALL be back-to-back: next start bit begins the cycle after the previous stop bit's last cycle; no idle gap.
REQ-018 Total busy duration SHALL be exactly 80*CLKS_PER_BIT cycles.
REQ-019 done SHALL pulse for exactly one cycle in the cycle busy falls; tx high at that point.
REQ-020 A send asserted in the same cycle done pulses SHALL be ignored; earliest accepted send is the cycle after.
REQ-021 Top FSM states: IDLE, SENDING; SENDING exits to IDLE after byte index 7 completes.
REQ-022 Byte serializer FSM states: IDLE, START, DATA, STOP; bit counter 0..7, baud counter 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
REQ-023 Byte index counter SHALL be 3 bits, 0..7, no wrap-around beyond 7 within a report.

Reset
REQ-024 Reset SHALL force: tx=1, busy=0, done=0, both FSMs IDLE, all counters 0, snapshot registers 0.
REQ-025 Reset asserted mid-report SHALL abort immediately (asynchronous): tx high with no partial frame completion; no done pulse.
REQ-026 First send after reset deassertion SHALL be accepted normally.

Structure
REQ-027 Shared package mastermind_uart_pkg SHALL hold: CLKS_PER_BIT default, ASCII constants (R, Z, z, CR, LF, '0', '?'), and both state enum typedefs.
REQ-028 One sub-module uart_tx_byte SHALL serialize a single byte (ports: clock, reset, start, data[7:0], tx, byte_done); mastermind_uart_tx sequences the 8 bytes.
REQ-029 tx SHALL be driven from a register (glitch-free).

Verification (CLKS_PER_BIT=4)
REQ-030 round=3, znarly=2, zood=1, send pulse -> bytes 52 33 5A 32 7A 31 0D 0A decoded by bench UART receiver; each bit 4 cycles; busy high 320 cycles; one done pulse.
REQ-031 round=12, znarly=0, zood=15 -> bytes 52 3F 5A 30 7A 3F 0D 0A.
REQ-032 Second send at cycle 50 of report, plus inputs changed at cycle 10 -> report unchanged, exactly one report sent, one done.
REQ-033 Reset asserted at cycle 100 of report -> tx=1 and busy=0 same cycle, no done; send after release -> full correct report.
REQ-034 send in done cycle ignored; send one cycle later accepted -> start bit begins next cycle, zero gap at idle between reports beyond one high cycle.
